// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output block.
//   - Default geometry of the PWM generator (counter width, pin count,
//     prescale ratio) and the all-ones duty code meaning 100%.
//   - Register addresses used by the SPI register block that feeds
//     en_out / en_pwm / duty, kept here so both sides agree.
//   - Pin mode encoding and the per-pin drive function.
package pwm_pkg;

  localparam int PWM_W       = 8;
  localparam int PWM_N_OUT   = 16;
  localparam int PWM_CLK_DIV = 13;
  localparam logic [PWM_W-1:0] PWM_DUTY_MAX = {PWM_W{1'b1}};

  localparam logic [7:0] REG_EN_OUT_LO = 8'h00;
  localparam logic [7:0] REG_EN_OUT_HI = 8'h01;
  localparam logic [7:0] REG_EN_PWM_LO = 8'h02;
  localparam logic [7:0] REG_EN_PWM_HI = 8'h03;
  localparam logic [7:0] REG_DUTY      = 8'h04;

  typedef enum logic [1:0] {
    PIN_LOW  = 2'd0,
    PIN_HIGH = 2'd1,
    PIN_PWM  = 2'd2
  } pin_mode_t;

  // Decode the two enable bits of one pin into its drive mode.
  function automatic pin_mode_t pin_mode(input logic en, input logic pwm_sel);
    if (!en)
      return PIN_LOW;
    else if (pwm_sel)
      return PIN_PWM;
    else
      return PIN_HIGH;
  endfunction

  // Level driven on one pin given its enables and the shared PWM level.
  function automatic logic pin_level(input logic en, input logic pwm_sel,
                                     input logic lvl);
    case (pin_mode(en, pwm_sel))
      PIN_LOW:  return 1'b0;
      PIN_HIGH: return 1'b1;
      default:  return lvl;
    endcase
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM counter.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   tick  out high for one clk cycle every CLK_DIV cycles (every cycle
//             when CLK_DIV is 1)
module pwm_prescaler #(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre;

  // With CLK_DIV=1 LAST is zero, so pre never leaves 0 and tick stays high.
  assign tick = (pre == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre <= '0;
    else if (tick)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

endmodule

// File: rtl/pwm_generator.sv
// Multi-pin PWM output stage driven by the SPI control registers.
// Each pin is forced low, held high, or follows one shared PWM waveform
// produced by a prescaled free-running counter compared against a
// shadowed duty value.
//   clk          in  system clock
//   rst          in  asynchronous active-high reset
//   en_out       in  per-pin enable; 0 forces the pin low
//   en_pwm       in  per-pin mode; 1 = PWM waveform, 0 = static high
//   duty         in  requested duty; high while cnt < duty, all-ones = 100%
//   out          out registered pin drive
//   period_start out one-cycle pulse after the counter wraps to 0
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int W       = PWM_W,
  parameter int N_OUT   = PWM_N_OUT,
  parameter int CLK_DIV = PWM_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_OUT-1:0] en_out,
  input  logic [N_OUT-1:0] en_pwm,
  input  logic [W-1:0]     duty,
  output logic [N_OUT-1:0] out,
  output logic             period_start
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic             tick;
  logic [W-1:0]     cnt;
  logic [W-1:0]     duty_sh;
  logic             primed;
  logic             wrap;
  logic             pwm_lvl;
  logic [N_OUT-1:0] out_nxt;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap = tick & (cnt == CNT_MAX);

  // All-ones duty is treated as 100% so the pin never dips low at cnt==max.
  assign pwm_lvl = (duty_sh == CNT_MAX) | (cnt < duty_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      duty_sh <= '0;
      primed  <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (tick)
        cnt <= cnt + 1'b1;
      // Shadow is only refreshed at a period boundary (or once right after
      // reset) so a mid-period duty write cannot glitch the waveform.
      if (wrap || !primed)
        duty_sh <= duty;
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pin
    assign out_nxt[gi] = pin_level(en_out[gi], en_pwm[gi], pwm_lvl);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_nxt;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
module tb_pwm_generator;

  localparam int DIV    = 13;
  localparam int STEPS  = 256;
  localparam int PERIOD = DIV * STEPS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] pout;
  logic        pstart;
  logic [15:0] pout1;
  logic        pstart1;

  int pass_cnt = 0;
  int total_cnt = 0;

  pwm_generator dut (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .out          (pout),
    .period_start (pstart)
  );

  pwm_generator #(.CLK_DIV(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .out          (pout1),
    .period_start (pstart1)
  );

  always #5 clk = ~clk;

  // Reference model: time-based. t = rising edges since reset release.
  // The counter value seen before edge t is floor(t/DIV) mod 256, a period
  // boundary happens on every PERIOD-th edge, and the duty seen by the
  // waveform is whatever was presented at the most recent boundary (or at
  // the very first edge after reset).
  int          t = 0;
  logic [7:0]  msh = '0;
  logic [15:0] exp_out = '0;
  logic        exp_ps = 1'b0;

  function automatic logic [15:0] pin_model(input int step, input logic [7:0] sh,
                                            input logic [15:0] eo, input logic [15:0] ep);
    logic        high;
    logic [15:0] r;
    high = (sh == 8'hFF) || (int'(sh) > step);
    for (int i = 0; i < 16; i++)
      r[i] = eo[i] && (!ep[i] || high);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t       <= 0;
      msh     <= '0;
      exp_out <= '0;
      exp_ps  <= 1'b0;
    end else begin
      exp_out <= pin_model((t / DIV) % STEPS, msh, en_out, en_pwm);
      exp_ps  <= ((t % PERIOD) == PERIOD - 1);
      if (t == 0 || (t % PERIOD) == PERIOD - 1)
        msh <= duty;
      t <= t + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // One clock: advance past the rising edge, sample on the falling edge and
  // compare against the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("model_out", 32'(pout), 32'(exp_out));
    check("model_period_start", 32'(pstart), 32'(exp_ps));
  endtask

  // Advance at least one cycle, then until period_start is seen (bounded).
  task automatic wait_ps(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pstart && n < PERIOD + 20);
    check("period_start_seen", 32'(pstart), 32'd1);
  endtask

  // Observe one full PWM period on pin b; optionally write duty mid-way.
  task automatic window(input int b, input int wr_at, input logic [7:0] wr_val,
                        output int highs, output int rises, output int falls,
                        output int misal);
    logic prev;
    highs = 0; rises = 0; falls = 0; misal = 0; prev = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == wr_at) duty = wr_val;
      tick();
      if (pout[b]) highs++;
      if (i > 0 && pout[b] && !prev) rises++;
      if (i > 0 && !pout[b] && prev) falls++;
      prev = pout[b];
      if ((pout & 16'hAAAA) != 16'h0000 && (pout & 16'hAAAA) != 16'hAAAA) misal++;
    end
  endtask

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] req;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, hi, ri, fa, mis;

    // Duty stays 0 through reset release, so every PWM-mode pin is low here.
    vecs[0] = '{16'h0001, 16'h0000, 16'h0001};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hAAAA, 16'h5555};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'hF0F0, 16'h0F0F, 16'hF0F0};
    vecs[5] = '{16'h1234, 16'h0000, 16'h1234};

    // Reset state
    repeat (3) tick();
    check("rst_out", 32'(pout), 32'h0);
    check("rst_period_start", 32'(pstart), 32'h0);
    check("rst_cnt", 32'(dut.cnt), 32'h0);
    rst = 1'b0;

    // Static-mode table
    foreach (vecs[k]) begin
      en_out = vecs[k].eo;
      en_pwm = vecs[k].ep;
      tick();
      check($sformatf("vec%0d_first", k), 32'(pout), 32'(vecs[k].req));
      tick();
      check($sformatf("vec%0d_steady", k), 32'(pout), 32'(vecs[k].req));
    end

    // Reset pulse mid-run with all pins enabled static high
    en_out = 16'hFFFF; en_pwm = 16'h0000;
    repeat (5) tick();
    check("pre_rst_out", 32'(pout), 32'hFFFF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(pout), 32'h0);
    check("async_rst_cnt", 32'(dut.cnt), 32'h0);
    check("async_rst_ps", 32'(pstart), 32'h0);
    @(negedge clk);
    repeat (2) tick();
    check("rst_hold_out", 32'(pout), 32'h0);
    rst = 1'b0;
    wait_ps(n);
    check("first_period_start_delay", 32'(n), 32'(PERIOD));

    // 50% duty on pin 0
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(n);
    window(0, -1, 8'h00, hi, ri, fa, mis);
    check("d80_high_cycles", 32'(hi), 32'(128 * DIV));
    check("d80_falls", 32'(fa), 32'd1);
    check("d80_rises", 32'(ri), 32'd0);
    check("d80_period", 32'(pstart), 32'd1);

    // duty 0: never high over 3 periods
    duty = 8'h00;
    wait_ps(n);
    for (int p = 0; p < 3; p++) begin
      window(0, -1, 8'h00, hi, ri, fa, mis);
      check("d00_high_cycles", 32'(hi), 32'd0);
    end

    // duty all-ones: never low over 3 periods
    duty = 8'hFF;
    wait_ps(n);
    for (int p = 0; p < 3; p++) begin
      window(0, -1, 8'h00, hi, ri, fa, mis);
      check("dff_high_cycles", 32'(hi), 32'(PERIOD));
    end

    // Mid-period duty write takes effect at the next period only
    duty = 8'h40;
    wait_ps(n);
    window(0, 400, 8'hC0, hi, ri, fa, mis);
    check("d40_kept_mid_write", 32'(hi), 32'(64 * DIV));
    window(0, -1, 8'h00, hi, ri, fa, mis);
    check("dc0_next_period", 32'(hi), 32'(192 * DIV));

    // Mixed pins: odd pins PWM in phase, even pins static high
    en_out = 16'hFFFF; en_pwm = 16'hAAAA; duty = 8'h80;
    wait_ps(n);
    window(1, -1, 8'h00, hi, ri, fa, mis);
    check("mix_odd_high_cycles", 32'(hi), 32'(128 * DIV));
    check("mix_odd_in_phase", 32'(mis), 32'd0);
    window(0, -1, 8'h00, hi, ri, fa, mis);
    check("mix_even_static", 32'(hi), 32'(PERIOD));

    // CLK_DIV=1 instance: period is exactly 256 cycles
    n = 0;
    do begin tick(); n++; end while (!pstart1 && n < 600);
    check("div1_ps_seen", 32'(pstart1), 32'd1);
    n = 0;
    do begin tick(); n++; end while (!pstart1 && n < 600);
    check("div1_period", 32'(n), 32'd256);

    // Randomized segments against the model
    for (int s = 0; s < 10; s++) begin
      int r;
      r = int'($urandom_range(0, 3));
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      duty   = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(200, 1500)) tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
